// File: rtl/level_decode_ramp.sv
// Decodes an inverted level code (code = MAX - level) and slews the registered
// output level toward the decoded target by STEP counts every TICK_DIV clocks.
module level_decode_ramp #(
    parameter int WIDTH    = 8,
    parameter int STEP     = 1,
    parameter int TICK_DIV = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_code,
    output logic [WIDTH-1:0] level,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [WIDTH-1:0] MAX       = '1;
    localparam logic [CW-1:0]    TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [WIDTH:0]   STEP_W    = (WIDTH + 1)'(STEP);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAMP_UP = 2'd1,
        RAMP_DN = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] level_q;
    logic [WIDTH-1:0] target_q;
    logic [CW-1:0]    tick_cnt_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] decoded;
    logic             tick;
    logic [WIDTH:0]   diff_up, diff_dn;
    logic [WIDTH:0]   amt_up, amt_dn;
    logic [WIDTH:0]   lvl_up_d, lvl_dn_d;

    // Handshake: a code transfers on a rising edge where in_valid && in_ready.
    // in_ready is high only in IDLE, so a code offered mid-ramp is held off.
    assign in_ready  = (state_q == IDLE);
    assign level     = level_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

    assign decoded = MAX - in_code;
    assign tick    = (tick_cnt_q == TICK_LAST);

    // One extra bit keeps the step arithmetic free of wrap; the min() clamp
    // guarantees the result never passes the target.
    always_comb begin
        diff_up  = {1'b0, target_q} - {1'b0, level_q};
        diff_dn  = {1'b0, level_q} - {1'b0, target_q};
        amt_up   = (diff_up < STEP_W) ? diff_up : STEP_W;
        amt_dn   = (diff_dn < STEP_W) ? diff_dn : STEP_W;
        lvl_up_d = {1'b0, level_q} + amt_up;
        lvl_dn_d = {1'b0, level_q} - amt_dn;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            level_q    <= '0;
            target_q   <= '0;
            tick_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        target_q   <= decoded;
                        tick_cnt_q <= '0;
                        if (decoded == level_q) begin
                            done_q <= 1'b1;
                        end else if (decoded > level_q) begin
                            state_q <= RAMP_UP;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= RAMP_DN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RAMP_UP: begin
                    if (tick) begin
                        tick_cnt_q <= '0;
                        level_q    <= lvl_up_d[WIDTH-1:0];
                        if (lvl_up_d == {1'b0, target_q}) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        tick_cnt_q <= tick_cnt_q + 1'b1;
                    end
                end
                RAMP_DN: begin
                    if (tick) begin
                        tick_cnt_q <= '0;
                        level_q    <= lvl_dn_d[WIDTH-1:0];
                        if (lvl_dn_d == {1'b0, target_q}) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        tick_cnt_q <= tick_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
